// File: rtl/add_seq_pkg.sv
// Shared definitions for the add sequencer: FSM states, bus widths and
// the address stepping helper used when moving to the next operand pair.
package add_seq_pkg;

  localparam int ADDR_W = 6;
  localparam int DATA_W = 32;
  localparam int IDX_W  = 3;
  localparam int CNT_W  = 4;

  // Each operand pair occupies two consecutive words of the operand memory
  localparam logic [ADDR_W-1:0] ADDR_STEP = ADDR_W'(2);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SETTLE  = 2'd1,
    PRESENT = 2'd2,
    FINISH  = 2'd3
  } state_e;

  // Address of the next operand pair; legal pair counts never wrap 6 bits
  function automatic logic [ADDR_W-1:0] next_addr(input logic [ADDR_W-1:0] cur);
    return cur + ADDR_STEP;
  endfunction

endpackage

// File: rtl/settle_timer.sv
// Counts the cycles the external adder needs to settle after an address
// change. expired flags the last settle cycle so the caller can capture.
module settle_timer
  import add_seq_pkg::*;
#(
  parameter int SETTLE_CYCLES = 4
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam logic [CNT_W-1:0] LAST_COUNT = CNT_W'(SETTLE_CYCLES - 1);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  // clear wins over enable so a fresh settle window always starts from zero
  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (enable) begin
      count_d = count_q + 1'b1;
    end
  end

  // Settle count register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expired = enable && (count_q == LAST_COUNT);

endmodule

// File: rtl/add_sequencer.sv
// Sweeps NUM_PAIRS operand pairs through an external adder: drives the pair
// address, waits SETTLE_CYCLES, captures sum/carry and hands each result to
// a valid/ready consumer. done pulses once after the last result is taken.
module add_sequencer
  import add_seq_pkg::*;
#(
  parameter int NUM_PAIRS     = 5,
  parameter int SETTLE_CYCLES = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic              abort,
  output logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] sum_in,
  input  logic              carry_in,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [DATA_W-1:0] res_sum,
  output logic              res_carry,
  output logic [IDX_W-1:0]  res_idx,
  output logic              busy,
  output logic              done
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_PAIRS - 1);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic              valid_q, valid_d;
  logic [DATA_W-1:0] sum_q, sum_d;
  logic              carry_q, carry_d;
  logic [IDX_W-1:0]  ridx_q, ridx_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic timer_clear;
  logic timer_enable;
  logic timer_expired;
  logic transfer;

  // The timer only runs in SETTLE and restarts whenever a window ends
  assign timer_enable = (state_q == SETTLE);
  assign timer_clear  = abort || timer_expired || (state_q != SETTLE);
  assign transfer     = valid_q && res_ready;

  settle_timer #(
    .SETTLE_CYCLES(SETTLE_CYCLES)
  ) u_settle_timer (
    .clk    (clk),
    .reset_n(reset_n),
    .clear  (timer_clear),
    .enable (timer_enable),
    .expired(timer_expired)
  );

  // Next-state and registered-output logic; abort overrides everything last
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    idx_d   = idx_q;
    valid_d = valid_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    ridx_d  = ridx_q;
    busy_d  = busy_q;
    done_d  = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = SETTLE;
          addr_d  = '0;
          idx_d   = '0;
        end
      end
      SETTLE: begin
        if (timer_expired) begin
          state_d = PRESENT;
          sum_d   = sum_in;
          carry_d = carry_in;
          ridx_d  = idx_q;
          valid_d = 1'b1;
        end
      end
      PRESENT: begin
        if (transfer) begin
          valid_d = 1'b0;
          if (idx_q == LAST_IDX) begin
            state_d = FINISH;
          end else begin
            state_d = SETTLE;
            idx_d   = idx_q + 1'b1;
            addr_d  = next_addr(addr_q);
          end
        end
      end
      FINISH: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // A result handed over in the same cycle as abort is simply dropped here
    if (abort) begin
      state_d = IDLE;
      addr_d  = '0;
      idx_d   = '0;
      valid_d = 1'b0;
    end

    busy_d = (state_d != IDLE);
    done_d = (state_d == FINISH);
  end

  // State and output registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      addr_q  <= '0;
      idx_q   <= '0;
      valid_q <= 1'b0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      ridx_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      idx_q   <= idx_d;
      valid_q <= valid_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      ridx_q  <= ridx_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign addr      = addr_q;
  assign res_valid = valid_q;
  assign res_sum   = sum_q;
  assign res_carry = carry_q;
  assign res_idx   = ridx_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_add_sequencer.sv
// Bench for add_sequencer: an operand memory plus adder model answers the
// DUT address, and expected results are queued when a sweep is started.
module tb_add_sequencer;

  localparam int NP = 5;
  localparam int SC = 4;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic        res_ready = 1'b0;
  logic [5:0]  addr;
  logic [31:0] sum_in;
  logic        carry_in;
  logic        res_valid;
  logic [31:0] res_sum;
  logic        res_carry;
  logic [2:0]  res_idx;
  logic        busy;
  logic        done;

  int errors = 0;
  int checks = 0;

  logic [31:0] memA [NP] = '{32'h00000001, 32'hFFFFFFFF, 32'h80000000, 32'h12345678, 32'h7FFFFFFF};
  logic [31:0] memB [NP] = '{32'h00000002, 32'h00000001, 32'h80000000, 32'hF0000000, 32'h00000001};

  typedef struct {
    logic [31:0] sum;
    logic        carry;
    logic [2:0]  idx;
    logic [5:0]  addr;
    int          cycle;
  } exp_t;

  exp_t expQ[$];

  add_sequencer #(
    .NUM_PAIRS(NP),
    .SETTLE_CYCLES(SC)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .start    (start),
    .abort    (abort),
    .addr     (addr),
    .sum_in   (sum_in),
    .carry_in (carry_in),
    .res_valid(res_valid),
    .res_ready(res_ready),
    .res_sum  (res_sum),
    .res_carry(res_carry),
    .res_idx  (res_idx),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  // Adder model fed from the operand memory at the pair the DUT addresses
  logic [32:0] addResult;
  int          pairSel;
  always_comb begin
    addResult = 33'd0;
    pairSel   = int'(addr) / 2;
    if (pairSel < NP) begin
      addResult = {1'b0, memA[pairSel]} + {1'b0, memB[pairSel]};
    end
  end
  assign sum_in   = addResult[31:0];
  assign carry_in = addResult[32];

  function automatic void pushSweep(input int first, input int last);
    for (int k = first; k <= last; k++) begin
      exp_t        e;
      logic [32:0] t;
      t       = {1'b0, memA[k]} + {1'b0, memB[k]};
      e.sum   = t[31:0];
      e.carry = t[32];
      e.idx   = 3'(k);
      e.addr  = 6'(2 * k);
      e.cycle = 1 + SC + k * (SC + 1);
      expQ.push_back(e);
    end
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic waitValid(input int budget, output bit ok, inout int n);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      tick();
      n++;
      if (res_valid === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    $display("[TB] reset state");
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (addr !== 6'd0) begin errors++; $display("[TB] FAIL reset_addr: got %h expected 00", addr); end
    checks++; if (res_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid: got %b expected 0", res_valid); end
    checks++; if (res_sum !== 32'd0) begin errors++; $display("[TB] FAIL reset_sum: got %h expected 0", res_sum); end
    checks++; if (res_carry !== 1'b0) begin errors++; $display("[TB] FAIL reset_carry: got %b expected 0", res_carry); end
    checks++; if (res_idx !== 3'd0) begin errors++; $display("[TB] FAIL reset_idx: got %0d expected 0", res_idx); end
    checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy_done: got %b%b expected 00", busy, done); end
    #2 reset_n = 1'b1;
    tick();
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL idle_after_reset: got busy=%b expected 0", busy); end
  endtask

  task automatic test_full_sweep();
    int   n;
    bit   ok;
    int   doneCycle;
    int   extraDone;
    exp_t e;
    $display("[TB] full sweep with ready held high");
    expQ.delete();
    pushSweep(0, NP - 1);
    res_ready = 1'b1;
    start = 1'b1;
    n = 0;
    tick();
    start = 1'b0;
    n = 1;
    for (int k = 0; k < NP; k++) begin
      waitValid(40, ok, n);
      checks++;
      if (!ok) begin errors++; $display("[TB] FAIL sweep_timeout k=%0d: got no res_valid expected one", k); return; end
      e = expQ.pop_front();
      checks++; if (n != e.cycle) begin errors++; $display("[TB] FAIL sweep_cycle k=%0d: got %0d expected %0d", k, n, e.cycle); end
      checks++; if (res_sum !== e.sum) begin errors++; $display("[TB] FAIL sweep_sum k=%0d: got %h expected %h", k, res_sum, e.sum); end
      checks++; if (res_carry !== e.carry) begin errors++; $display("[TB] FAIL sweep_carry k=%0d: got %b expected %b", k, res_carry, e.carry); end
      checks++; if (res_idx !== e.idx) begin errors++; $display("[TB] FAIL sweep_idx k=%0d: got %0d expected %0d", k, res_idx, e.idx); end
      checks++; if (addr !== e.addr) begin errors++; $display("[TB] FAIL sweep_addr k=%0d: got %0d expected %0d", k, addr, e.addr); end
    end
    doneCycle = -1;
    for (int i = 0; i < 10; i++) begin
      tick();
      n++;
      if (done === 1'b1) begin doneCycle = n; break; end
    end
    checks++; if (doneCycle != 1 + SC + (NP - 1) * (SC + 1) + 1) begin errors++; $display("[TB] FAIL sweep_done_cycle: got %0d expected %0d", doneCycle, 1 + SC + (NP - 1) * (SC + 1) + 1); end
    // start while done is high must be ignored
    start = 1'b1;
    tick();
    start = 1'b0;
    extraDone = 0;
    for (int i = 0; i < 8; i++) begin
      if (done === 1'b1 || busy === 1'b1 || res_valid === 1'b1) extraDone++;
      tick();
    end
    checks++; if (extraDone != 0) begin errors++; $display("[TB] FAIL start_during_done: got %0d active cycles expected 0", extraDone); end
    checks++; if (addr !== 6'd8) begin errors++; $display("[TB] FAIL addr_hold_after_finish: got %0d expected 8", addr); end
  endtask

  task automatic test_backpressure();
    int   n;
    bit   ok;
    exp_t e;
    $display("[TB] backpressure on idx2");
    expQ.delete();
    pushSweep(0, NP - 1);
    res_ready = 1'b1;
    start = 1'b1;
    n = 0;
    tick();
    start = 1'b0;
    for (int k = 0; k < 2; k++) begin
      waitValid(40, ok, n);
      checks++;
      if (!ok) begin errors++; $display("[TB] FAIL bp_timeout k=%0d: got no res_valid expected one", k); return; end
      e = expQ.pop_front();
      checks++; if (res_idx !== e.idx || res_sum !== e.sum) begin errors++; $display("[TB] FAIL bp_early k=%0d: got idx=%0d sum=%h expected idx=%0d sum=%h", k, res_idx, res_sum, e.idx, e.sum); end
    end
    tick();
    res_ready = 1'b0;
    waitValid(40, ok, n);
    checks++;
    if (!ok) begin errors++; $display("[TB] FAIL bp_timeout k=2: got no res_valid expected one"); return; end
    e = expQ[0];
    for (int j = 0; j < 7; j++) begin
      checks++;
      if (res_valid !== 1'b1 || res_sum !== e.sum || res_idx !== 3'd2 || addr !== 6'd4) begin
        errors++;
        $display("[TB] FAIL bp_hold cyc=%0d: got v=%b sum=%h idx=%0d addr=%0d expected v=1 sum=%h idx=2 addr=4", j, res_valid, res_sum, res_idx, addr, e.sum);
      end
      start = (j == 3);
      tick();
    end
    start = 1'b0;
    checks++; if (res_valid !== 1'b1) begin errors++; $display("[TB] FAIL bp_still_valid: got %b expected 1", res_valid); end
    res_ready = 1'b1;
    e = expQ.pop_front();
    checks++; if (res_sum !== e.sum || res_carry !== e.carry) begin errors++; $display("[TB] FAIL bp_accept: got %h/%b expected %h/%b", res_sum, res_carry, e.sum, e.carry); end
    for (int k = 3; k < NP; k++) begin
      waitValid(40, ok, n);
      checks++;
      if (!ok) begin errors++; $display("[TB] FAIL bp_resume_timeout k=%0d: got no res_valid expected one", k); return; end
      e = expQ.pop_front();
      checks++; if (res_idx !== e.idx || res_sum !== e.sum || addr !== e.addr) begin errors++; $display("[TB] FAIL bp_resume k=%0d: got idx=%0d sum=%h addr=%0d expected idx=%0d sum=%h addr=%0d", k, res_idx, res_sum, addr, e.idx, e.sum, e.addr); end
    end
    ok = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (done === 1'b1) begin ok = 1'b1; break; end
    end
    checks++; if (!ok) begin errors++; $display("[TB] FAIL bp_done: got no done pulse expected one"); end
    repeat (3) tick();
  endtask

  task automatic test_abort();
    int   n;
    bit   ok;
    int   bad;
    exp_t e;
    $display("[TB] abort during settle of idx3");
    expQ.delete();
    pushSweep(0, 2);
    res_ready = 1'b1;
    start = 1'b1;
    n = 0;
    tick();
    start = 1'b0;
    for (int k = 0; k < 3; k++) begin
      waitValid(40, ok, n);
      checks++;
      if (!ok) begin errors++; $display("[TB] FAIL abort_timeout k=%0d: got no res_valid expected one", k); return; end
      e = expQ.pop_front();
      checks++; if (res_idx !== e.idx || res_sum !== e.sum) begin errors++; $display("[TB] FAIL abort_pre k=%0d: got idx=%0d sum=%h expected idx=%0d sum=%h", k, res_idx, res_sum, e.idx, e.sum); end
    end
    tick();
    tick();
    checks++; if (busy !== 1'b1 || addr !== 6'd6 || res_valid !== 1'b0) begin errors++; $display("[TB] FAIL abort_setup: got busy=%b addr=%0d v=%b expected 1/6/0", busy, addr, res_valid); end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL abort_busy: got %b expected 0", busy); end
    checks++; if (addr !== 6'd0) begin errors++; $display("[TB] FAIL abort_addr: got %0d expected 0", addr); end
    checks++; if (res_valid !== 1'b0 || done !== 1'b0) begin errors++; $display("[TB] FAIL abort_valid_done: got %b%b expected 00", res_valid, done); end
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (done === 1'b1 || res_valid === 1'b1 || busy === 1'b1) bad++;
    end
    checks++; if (bad != 0) begin errors++; $display("[TB] FAIL abort_quiet: got %0d active cycles expected 0", bad); end
    pushSweep(0, 0);
    start = 1'b1;
    n = 0;
    tick();
    start = 1'b0;
    n = 1;
    waitValid(40, ok, n);
    checks++;
    if (!ok) begin errors++; $display("[TB] FAIL abort_restart_timeout: got no res_valid expected one"); return; end
    e = expQ.pop_front();
    checks++; if (res_idx !== e.idx || res_sum !== e.sum || addr !== e.addr || n != e.cycle) begin errors++; $display("[TB] FAIL abort_restart: got idx=%0d sum=%h addr=%0d cyc=%0d expected idx=%0d sum=%h addr=%0d cyc=%0d", res_idx, res_sum, addr, n, e.idx, e.sum, e.addr, e.cycle); end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    bad = 0;
    for (int i = 0; i < 4; i++) begin
      if (done === 1'b1 || busy === 1'b1) bad++;
      tick();
    end
    checks++; if (bad != 0) begin errors++; $display("[TB] FAIL abort_with_transfer: got %0d active cycles expected 0", bad); end
  endtask

  task automatic test_reset_mid();
    int   n;
    bit   ok;
    int   bad;
    exp_t e;
    $display("[TB] async reset in PRESENT");
    expQ.delete();
    pushSweep(0, 0);
    res_ready = 1'b0;
    start = 1'b1;
    n = 0;
    tick();
    start = 1'b0;
    waitValid(40, ok, n);
    checks++;
    if (!ok) begin errors++; $display("[TB] FAIL rst_mid_timeout: got no res_valid expected one"); return; end
    e = expQ.pop_front();
    checks++; if (res_sum !== e.sum || res_idx !== e.idx) begin errors++; $display("[TB] FAIL rst_mid_pre: got %h/%0d expected %h/%0d", res_sum, res_idx, e.sum, e.idx); end
    #3 reset_n = 1'b0;
    #1;
    checks++;
    if (res_valid !== 1'b0 || res_sum !== 32'd0 || res_carry !== 1'b0 || res_idx !== 3'd0 ||
        addr !== 6'd0 || busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("[TB] FAIL rst_mid_async: got v=%b sum=%h c=%b idx=%0d addr=%0d busy=%b done=%b expected all zero",
               res_valid, res_sum, res_carry, res_idx, addr, busy, done);
    end
    @(posedge clk);
    #3 reset_n = 1'b1;
    res_ready = 1'b1;
    bad = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (busy === 1'b1 || res_valid === 1'b1) bad++;
    end
    checks++; if (bad != 0) begin errors++; $display("[TB] FAIL rst_mid_waits: got %0d active cycles expected 0", bad); end
    pushSweep(0, 0);
    start = 1'b1;
    n = 0;
    tick();
    start = 1'b0;
    n = 1;
    waitValid(40, ok, n);
    checks++;
    if (!ok) begin errors++; $display("[TB] FAIL rst_mid_restart_timeout: got no res_valid expected one"); return; end
    e = expQ.pop_front();
    checks++; if (res_sum !== e.sum || res_idx !== e.idx || n != e.cycle) begin errors++; $display("[TB] FAIL rst_mid_restart: got %h/%0d cyc=%0d expected %h/%0d cyc=%0d", res_sum, res_idx, n, e.sum, e.idx, e.cycle); end
    abort = 1'b1;
    tick();
    abort = 1'b0;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL global_timeout: got no finish expected finish");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    test_reset();
    test_full_sweep();
    test_backpressure();
    test_abort();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
